pipe_hazard_ctrl: RTL

Central hazard and stall controller for the 5-stage RISC-V pipeline. It drives enable/flush for PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It sequences data-memory accesses from the MEM stage through a req/ack handshake with a timeout, and generates EX-stage operand forwarding selects. Load-use, branch-redirect and memory-wait stalls are all resolved here.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/fwd_unit.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/fwd_unit.sv
// Single-operand EX forwarding select; the younger MEM result beats WB.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs_i,
  input  logic [4:0] mem_rd_i,
  input  logic       mem_reg_we_i,
  input  logic [4:0] wb_rd_i,
  input  logic       wb_reg_we_i,
  output fwd_sel_t   sel_o
);

  // Pick the most recent in-flight producer of the source register.
  always_comb begin
    sel_o = FWD_RF;
    if (mem_reg_we_i && (mem_rd_i != REG_X0) && (mem_rd_i == ex_rs_i)) begin
      sel_o = FWD_MEM;
    end else if (wb_reg_we_i && (wb_rd_i != REG_X0) && (wb_rd_i == ex_rs_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: stage enables and
// flushes, data-memory handshake with timeout, and EX operand forwarding.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_reg_we,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ack,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             mem_reg_we,
  input  logic             wb_reg_we,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             dmem_req,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  hz_state_t        state_q, state_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             bus_err_q, bus_err_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             mem_stall;
  logic             load_use;
  fwd_sel_t         fwd_a_sel, fwd_b_sel;

  fwd_unit u_fwd_a (
    .ex_rs_i      (ex_rs1),
    .mem_rd_i     (mem_rd),
    .mem_reg_we_i (mem_reg_we),
    .wb_rd_i      (wb_rd),
    .wb_reg_we_i  (wb_reg_we),
    .sel_o        (fwd_a_sel)
  );

  fwd_unit u_fwd_b (
    .ex_rs_i      (ex_rs2),
    .mem_rd_i     (mem_rd),
    .mem_reg_we_i (mem_reg_we),
    .wb_rd_i      (wb_rd),
    .wb_reg_we_i  (wb_reg_we),
    .sel_o        (fwd_b_sel)
  );

  assign fwd_a     = rst_n ? fwd_a_sel : FWD_RF;
  assign fwd_b     = rst_n ? fwd_b_sel : FWD_RF;
  assign bus_err   = bus_err_q;
  assign stall_cnt = stall_cnt_q;

  assign load_use = ex_is_load && ex_reg_we && (ex_rd != REG_X0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  // Memory FSM next-state plus prioritised enable/flush generation.
  always_comb begin
    state_d      = state_q;
    tmo_cnt_d    = tmo_cnt_q;
    bus_err_d    = bus_err_q;
    mem_stall    = 1'b0;
    dmem_req     = 1'b0;
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;

    case (state_q)
      IDLE: begin
        dmem_req = mem_req;
        if (mem_req && !dmem_ack) begin
          mem_stall = 1'b1;
          tmo_cnt_d = TMO_W'(1);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          tmo_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          mem_stall = 1'b1;
          if (tmo_cnt_q == TMO_LAST) begin
            state_d   = ERR;
            bus_err_d = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
        end
      end
      default: begin
        dmem_req = 1'b0;
      end
    endcase

    if (state_q == ERR) begin
      // Everything frozen until reset.
      dmem_req = 1'b0;
    end else if (mem_stall) begin
      // Hold the front of the pipe; older instruction in WB retires, bubble follows.
      mem_wb_en    = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      // Redirect: squash the two wrong-path instructions behind the branch.
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      id_ex_en    = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      // One bubble into EX; the consumer picks the load data up from WB.
      id_ex_en    = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
    end else begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
    end

    if (!rst_n) begin
      dmem_req     = 1'b0;
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;
    end
  end

  // FSM, timeout counter, sticky error and saturating stall counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tmo_cnt_q   <= '0;
      bus_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      bus_err_q <= bus_err_d;
      if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
